// File: rtl/time_pkg.sv
// time_pkg: shared constants, the hh:mm:ss record and the 12-hour view helper
// used by the time_keeper block.
package time_pkg;

  localparam int unsigned TIME_W = 7;

  localparam logic [TIME_W-1:0] SEC_MAX  = 7'd59;
  localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
  localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;

  typedef struct packed {
    logic [TIME_W-1:0] hh;
    logic [TIME_W-1:0] mm;
    logic [TIME_W-1:0] ss;
  } hms_t;

  // 24-hour value -> 12-hour display value (0 shows as 12).
  function automatic logic [TIME_W-1:0] to12h(input logic [TIME_W-1:0] hh);
    if (hh == '0) begin
      return 7'd12;
    end else if (hh > 7'd12) begin
      return hh - 7'd12;
    end else begin
      return hh;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk_2MHz by DIV and produces a one-cycle enable.
// Ports:
//   clk_2MHz  system clock (rising edge)
//   reset     synchronous, active-high reset
//   en        count enable; the counter holds while low
//   clr       synchronous clear, overrides en and suppresses tick
//   tick      combinational pulse in the cycle where the counter wraps
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_2MHz,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cntQ;

  assign tick = en & ~clr & (cntQ == LAST);

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (en) begin
      cntQ <= (cntQ == LAST) ? '0 : cntQ + CNT_W'(1);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: single-clock 24-hour time-of-day counter with run/pause,
// validated set, carry pulses, 12-hour display view and optional alarm.
// Optional feature macro: TIME_KEEPER_ALARM_EN (alarm compare built when defined,
// otherwise alarm is tied low and the alarm inputs are ignored).
// Ports:
//   clk_2MHz, reset          clock, synchronous active-high reset
//   run                      count enable (time and prescaler hold while low)
//   set, setHH/MM/SS         load request and 24-hour load values
//   mode12                   show outHH/pm in 12-hour form
//   almHH/almMM, alarm_en    alarm time and enable
//   outHH/outMM/outSS, pm    current time
//   sec_tick, day_wrap       one-cycle pulses on second advance / midnight wrap
//   set_err, alarm           one-cycle pulses on rejected set / alarm match
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 2000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic              clk_2MHz,
  input  logic              reset,
  input  logic              run,
  input  logic              set,
  input  logic [TIME_W-1:0] setHH,
  input  logic [TIME_W-1:0] setMM,
  input  logic [TIME_W-1:0] setSS,
  input  logic              mode12,
  input  logic [TIME_W-1:0] almHH,
  input  logic [TIME_W-1:0] almMM,
  input  logic              alarm_en,
  output logic [TIME_W-1:0] outHH,
  output logic [TIME_W-1:0] outMM,
  output logic [TIME_W-1:0] outSS,
  output logic              pm,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              set_err,
  output logic              alarm
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  hms_t curQ;
  hms_t nxt;
  logic wrapsDay;
  logic tick;
  logic prescEn;
  logic setValid;
  logic secTickQ, dayWrapQ, setErrQ;

  assign prescEn  = run & ~set;
  assign setValid = (setHH <= HOUR_MAX) && (setMM <= MIN_MAX) && (setSS <= SEC_MAX);

  tick_prescaler #(
    .DIV(DIV)
  ) uPrescaler (
    .clk_2MHz(clk_2MHz),
    .reset   (reset),
    .en      (prescEn),
    .clr     (set),
    .tick    (tick)
  );

  // Time after one second, with carries.
  always_comb begin
    nxt      = curQ;
    wrapsDay = 1'b0;
    if (curQ.ss >= SEC_MAX) begin
      nxt.ss = '0;
      if (curQ.mm >= MIN_MAX) begin
        nxt.mm = '0;
        if (curQ.hh >= HOUR_MAX) begin
          nxt.hh   = '0;
          wrapsDay = 1'b1;
        end else begin
          nxt.hh = curQ.hh + 7'd1;
        end
      end else begin
        nxt.mm = curQ.mm + 7'd1;
      end
    end else begin
      nxt.ss = curQ.ss + 7'd1;
    end
  end

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      curQ     <= '0;
      secTickQ <= 1'b0;
      dayWrapQ <= 1'b0;
      setErrQ  <= 1'b0;
    end else begin
      secTickQ <= 1'b0;
      dayWrapQ <= 1'b0;
      setErrQ  <= 1'b0;
      if (set) begin
        // set outranks run and any pending wrap; an invalid set leaves time alone
        if (setValid) begin
          curQ <= '{hh: setHH, mm: setMM, ss: setSS};
        end else begin
          setErrQ <= 1'b1;
        end
      end else if (tick) begin
        curQ     <= nxt;
        secTickQ <= 1'b1;
        dayWrapQ <= wrapsDay;
      end
    end
  end

`ifdef TIME_KEEPER_ALARM_EN
  logic alarmHit;
  logic alarmQ;

  // Alarm only on a tick into hh:mm:00, never on a set.
  assign alarmHit = alarm_en && (nxt.hh == almHH) && (nxt.mm == almMM) && (nxt.ss == '0);

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      alarmQ <= 1'b0;
    end else begin
      alarmQ <= ~set & tick & alarmHit;
    end
  end

  assign alarm = alarmQ;
`else
  logic unused_alarm;
  assign unused_alarm = ^{almHH, almMM, alarm_en};
  assign alarm = 1'b0;
`endif

  assign outHH    = mode12 ? to12h(curQ.hh) : curQ.hh;
  assign outMM    = curQ.mm;
  assign outSS    = curQ.ss;
  assign pm       = mode12 & (curQ.hh >= 7'd12);
  assign sec_tick = secTickQ;
  assign day_wrap = dayWrapQ;
  assign set_err  = setErrQ;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  localparam int DIV = 10;
`ifdef TIME_KEEPER_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, run, set, mode12, alarm_en;
  logic [6:0] setHH, setMM, setSS, almHH, almMM;
  logic [6:0] outHH, outMM, outSS;
  logic pm, sec_tick, day_wrap, set_err, alarm;

  int total = 0;
  int bad = 0;

  // Reference model: time as seconds of day, prescaler as phase count.
  int mSecs = 0;
  int mPhase = 0;
  bit eTick, eWrap, eErr, eAlm;

  always #5 clk = ~clk;

  time_keeper #(
    .CLK_HZ (DIV),
    .TICK_HZ(1)
  ) dut (
    .clk_2MHz(clk),
    .reset   (reset),
    .run     (run),
    .set     (set),
    .setHH   (setHH),
    .setMM   (setMM),
    .setSS   (setSS),
    .mode12  (mode12),
    .almHH   (almHH),
    .almMM   (almMM),
    .alarm_en(alarm_en),
    .outHH   (outHH),
    .outMM   (outMM),
    .outSS   (outSS),
    .pm      (pm),
    .sec_tick(sec_tick),
    .day_wrap(day_wrap),
    .set_err (set_err),
    .alarm   (alarm)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    int sh, sm, ss;
    sh = int'(setHH); sm = int'(setMM); ss = int'(setSS);
    eTick = 0; eWrap = 0; eErr = 0; eAlm = 0;
    if (reset) begin
      mSecs = 0;
      mPhase = 0;
    end else if (set) begin
      mPhase = 0;
      if (sh < 24 && sm < 60 && ss < 60) mSecs = sh * 3600 + sm * 60 + ss;
      else eErr = 1;
    end else if (run) begin
      mPhase++;
      if (mPhase == DIV) begin
        mPhase = 0;
        mSecs = (mSecs + 1) % 86400;
        eTick = 1;
        eWrap = (mSecs == 0);
        eAlm = ALM && alarm_en && (mSecs == int'(almHH) * 3600 + int'(almMM) * 60);
      end
    end
  endtask

  task automatic compareAll();
    int hh, dispH;
    hh = mSecs / 3600;
    dispH = mode12 ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
    chk("outHH", outHH, dispH);
    chk("outMM", outMM, (mSecs / 60) % 60);
    chk("outSS", outSS, mSecs % 60);
    chk("pm", pm, (mode12 && hh >= 12) ? 1 : 0);
    chk("sec_tick", sec_tick, eTick);
    chk("day_wrap", day_wrap, eWrap);
    chk("set_err", set_err, eErr);
    chk("alarm", alarm, eAlm);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic loadTime(input int h, input int m, input int s);
    set = 1'b1;
    setHH = 7'(h); setMM = 7'(m); setSS = 7'(s);
    cycle();
    set = 1'b0;
  endtask

  typedef struct {
    int h, m, s;
    int expErr, expH, expM, expS;
  } set_vec_t;

  typedef struct {
    int h, m12, expH, expPm;
  } view_vec_t;

  set_vec_t setTab[7];
  view_vec_t viewTab[8];

  initial begin
    int n;
    bit found;
    reset = 1'b1; run = 1'b0; set = 1'b0; mode12 = 1'b0; alarm_en = 1'b0;
    setHH = '0; setMM = '0; setSS = '0; almHH = '0; almMM = '0;

    setTab[0] = '{12, 0, 0, 0, 12, 0, 0};
    setTab[1] = '{24, 10, 0, 1, 12, 0, 0};
    setTab[2] = '{23, 59, 59, 0, 23, 59, 59};
    setTab[3] = '{5, 60, 0, 1, 23, 59, 59};
    setTab[4] = '{5, 0, 60, 1, 23, 59, 59};
    setTab[5] = '{0, 0, 0, 0, 0, 0, 0};
    setTab[6] = '{127, 0, 0, 1, 0, 0, 0};

    viewTab[0] = '{0, 1, 12, 0};
    viewTab[1] = '{12, 1, 12, 1};
    viewTab[2] = '{13, 1, 1, 1};
    viewTab[3] = '{0, 0, 0, 0};
    viewTab[4] = '{23, 1, 11, 1};
    viewTab[5] = '{11, 1, 11, 0};
    viewTab[6] = '{1, 1, 1, 0};
    viewTab[7] = '{13, 0, 13, 0};

    // Reset state
    cycle();
    cycle();
    chk("reset_HH", outHH, 0);
    chk("reset_SS", outSS, 0);
    chk("reset_tick", sec_tick, 0);
    mode12 = 1'b1;
    #1;
    chk("reset_HH_12h", outHH, 12);
    chk("reset_pm_12h", pm, 0);
    mode12 = 1'b0;

    // Ticks at cycles 10 and 20 after reset release
    reset = 1'b0; run = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      cycle();
      chk("tick_cycle", sec_tick, (c == 10 || c == 20) ? 1 : 0);
      if (c == 10) chk("ss_after_tick1", outSS, 1);
      if (c == 20) chk("ss_after_tick2", outSS, 2);
    end

    // Midnight wrap
    loadTime(23, 59, 59);
    for (int c = 1; c <= 10; c++) cycle();
    chk("wrap_tick", sec_tick, 1);
    chk("wrap_flag", day_wrap, 1);
    chk("wrap_HH", outHH, 0);
    chk("wrap_SS", outSS, 0);

    // Set validation table
    run = 1'b0;
    foreach (setTab[i]) begin
      set = 1'b1;
      setHH = 7'(setTab[i].h); setMM = 7'(setTab[i].m); setSS = 7'(setTab[i].s);
      cycle();
      chk("settab_err", set_err, setTab[i].expErr);
      chk("settab_HH", outHH, setTab[i].expH);
      chk("settab_MM", outMM, setTab[i].expM);
      chk("settab_SS", outSS, setTab[i].expS);
    end
    set = 1'b0;
    cycle();

    // 12-hour view table
    foreach (viewTab[i]) begin
      mode12 = 1'b0;
      loadTime(viewTab[i].h, 0, 0);
      mode12 = viewTab[i].m12[0];
      #1;
      chk("view_HH", outHH, viewTab[i].expH);
      chk("view_pm", pm, viewTab[i].expPm);
    end
    mode12 = 1'b0;

    // Pause after cnt=4, resume latency
    reset = 1'b1; cycle(); reset = 1'b0; run = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    run = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      chk("pause_no_tick", sec_tick, 0);
    end
    run = 1'b1;
    n = 0; found = 0;
    while (!found && n < 20) begin
      cycle();
      n++;
      if (sec_tick) found = 1;
    end
    chk("resume_latency", n, 6);

    // Set colliding with prescaler wrap: set wins
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int c = 0; c < 9; c++) cycle();
    loadTime(10, 20, 30);
    chk("setwrap_no_tick", sec_tick, 0);
    chk("setwrap_HH", outHH, 10);

    // Reset together with set
    reset = 1'b1; set = 1'b1; setHH = 7'd5; setMM = 7'd5; setSS = 7'd5;
    cycle();
    chk("rstset_HH", outHH, 0);
    chk("rstset_SS", outSS, 0);
    reset = 1'b0; set = 1'b0;

    // Alarm
    almHH = 7'd1; almMM = 7'd2; alarm_en = 1'b1;
    loadTime(1, 1, 59);
    for (int c = 0; c < 10; c++) cycle();
    chk("alarm_hit", alarm, ALM ? 1 : 0);
    chk("alarm_tick", sec_tick, 1);
    chk("alarm_MM", outMM, 2);
    alarm_en = 1'b0;
    loadTime(1, 1, 59);
    for (int c = 0; c < 10; c++) cycle();
    chk("alarm_disabled", alarm, 0);
    alarm_en = 1'b1;
    loadTime(1, 2, 0);
    chk("alarm_on_set", alarm, 0);

    // Randomized run against the model
    almHH = 7'($urandom_range(0, 23)); almMM = 7'($urandom_range(0, 59));
    for (int c = 0; c < 3000; c++) begin
      int k, base;
      reset = ($urandom_range(0, 299) == 0);
      set = ($urandom_range(0, 24) == 0);
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode12 = ~mode12;
      if ($urandom_range(0, 63) == 0) alarm_en = ~alarm_en;
      if (set) begin
        k = $urandom_range(0, 3);
        case (k)
          0: begin
            setHH = 7'($urandom_range(0, 127));
            setMM = 7'($urandom_range(0, 127));
            setSS = 7'($urandom_range(0, 127));
          end
          1: begin
            setHH = 7'd23; setMM = 7'd59; setSS = 7'($urandom_range(50, 60));
          end
          2: begin
            base = (int'(almHH) * 3600 + int'(almMM) * 60 - $urandom_range(0, 6) + 86400) % 86400;
            setHH = 7'(base / 3600); setMM = 7'((base / 60) % 60); setSS = 7'(base % 60);
          end
          default: begin
            setHH = 7'($urandom_range(0, 24));
            setMM = 7'($urandom_range(0, 60));
            setSS = 7'($urandom_range(0, 60));
          end
        endcase
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
